// File: rtl/prime_search_ctrl.sv
// Search controller: gathers RNG words into a candidate, forces MSB/LSB, runs miller_rabin and retries on composite.
// Optional PRIME_SIEVE_EN adds a small-prime trial-division reject in COND before the tester is launched.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; done pulses here on return
// S_GATHER | one RNG word per cycle into the candidate, low word first
// S_COND   | force MSB/LSB, count the try, optional sieve reject
// S_LAUNCH | one-cycle mr_reset pulse, wait counter cleared
// S_WAIT   | wait for tester verdict or timeout
module prime_search_ctrl #(
   parameter int WORDSIZE  = 32,
   parameter int MAX_TRIES = 256,
   parameter int ACCURACY  = 20,
   parameter int TIMEOUT   = 1048576
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [15:0]             rng_word,
   input  logic                    mr_finish,
   input  logic                    mr_prime,
   output logic [WORDSIZE-1:0]     mr_candidate,
   output logic [2*WORDSIZE-1:0]   mr_accuracy,
   output logic                    mr_reset,
   output logic                    busy,
   output logic                    done,
   output logic                    prime_valid,
   output logic                    fail,
   output logic [WORDSIZE-1:0]     prime_out,
   output logic [15:0]             tries
);

   localparam int NW      = WORDSIZE / 16;
   localparam int WCW     = (NW > 1) ? $clog2(NW) : 1;
   localparam int TW_RAW  = $clog2(TIMEOUT + 1);
   localparam int TW      = (TW_RAW < 2) ? 2 : TW_RAW;
   localparam logic [15:0]          MAX_EFF    = (MAX_TRIES > 65535) ? 16'hFFFF : 16'(MAX_TRIES);
   localparam logic [WORDSIZE-1:0]  FORCE_MASK = {1'b1, {(WORDSIZE-2){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_GATHER,
      S_COND,
      S_LAUNCH,
      S_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [WORDSIZE-1:0] cand_q, cand_d;
   logic [WCW-1:0]      word_cnt_q, word_cnt_d;
   logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
   logic [15:0]         tries_q, tries_d;
   logic                prime_valid_q, prime_valid_d;
   logic                fail_q, fail_d;
   logic [WORDSIZE-1:0] prime_out_q, prime_out_d;
   logic                done_q, done_d;
   logic                sieve_hit;
   logic                composite;

`ifdef PRIME_SIEVE_EN
   logic [WORDSIZE-1:0] cand_forced;
   assign cand_forced = cand_q | FORCE_MASK;
   assign sieve_hit = ((cand_forced % WORDSIZE'(3))  == '0) ||
                      ((cand_forced % WORDSIZE'(5))  == '0) ||
                      ((cand_forced % WORDSIZE'(7))  == '0) ||
                      ((cand_forced % WORDSIZE'(11)) == '0) ||
                      ((cand_forced % WORDSIZE'(13)) == '0);
`else
   assign sieve_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         cand_q        <= '0;
         word_cnt_q    <= '0;
         wait_cnt_q    <= '0;
         tries_q       <= '0;
         prime_valid_q <= 1'b0;
         fail_q        <= 1'b0;
         prime_out_q   <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cand_q        <= cand_d;
         word_cnt_q    <= word_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         tries_q       <= tries_d;
         prime_valid_q <= prime_valid_d;
         fail_q        <= fail_d;
         prime_out_q   <= prime_out_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cand_d        = cand_q;
      word_cnt_d    = word_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      tries_d       = tries_q;
      prime_valid_d = prime_valid_q;
      fail_d        = fail_q;
      prime_out_d   = prime_out_q;
      done_d        = 1'b0;
      composite     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tries_d       = '0;
               prime_valid_d = 1'b0;
               fail_d        = 1'b0;
               prime_out_d   = '0;
               word_cnt_d    = '0;
               state_d       = S_GATHER;
            end
         end
         S_GATHER: begin
            for (int k = 0; k < NW; k++) begin
               if (word_cnt_q == WCW'(k)) cand_d[16*k +: 16] = rng_word;
            end
            if (word_cnt_q == WCW'(NW - 1)) begin
               word_cnt_d = '0;
               state_d    = S_COND;
            end else begin
               word_cnt_d = word_cnt_q + WCW'(1);
            end
         end
         S_COND: begin
            cand_d  = cand_q | FORCE_MASK;
            tries_d = (tries_q == 16'hFFFF) ? tries_q : tries_q + 16'd1;
            if (sieve_hit) composite = 1'b1;
            else           state_d   = S_LAUNCH;
         end
         S_LAUNCH: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + TW'(1);
            // the first two WAIT cycles may still see a finish left over from the previous try
            if (mr_finish && (wait_cnt_q >= TW'(2))) begin
               if (mr_prime) begin
                  prime_out_d   = cand_q;
                  prime_valid_d = 1'b1;
                  done_d        = 1'b1;
                  state_d       = S_IDLE;
               end else begin
                  composite = 1'b1;
               end
            end else if (wait_cnt_q == TW'(TIMEOUT)) begin
               composite = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // tries_d already holds the count including the current candidate
      if (composite) begin
         if (tries_d >= MAX_EFF) begin
            fail_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            word_cnt_d = '0;
            state_d    = S_GATHER;
         end
      end
   end

   assign mr_candidate = cand_q;
   assign mr_accuracy  = (2*WORDSIZE)'(ACCURACY);
   assign mr_reset     = (state_q == S_LAUNCH);
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign prime_valid  = prime_valid_q;
   assign fail         = fail_q;
   assign prime_out    = prime_out_q;
   assign tries        = tries_q;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// Scoreboard bench for prime_search_ctrl: searches push expected results, a negedge monitor checks them on done.
// Runs with MAX_TRIES=4, TIMEOUT=16; the sieve vector adapts to PRIME_SIEVE_EN.
module tb_prime_search_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] rng_word = 16'h0;
   logic        mr_finish, mr_prime;
   logic [31:0] mr_candidate, prime_out;
   logic [63:0] mr_accuracy;
   logic        mr_reset, busy, done, prime_valid, fail;
   logic [15:0] tries;

   always #5 clk = ~clk;

   prime_search_ctrl #(.WORDSIZE(32), .MAX_TRIES(4), .ACCURACY(20), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .rng_word(rng_word),
      .mr_finish(mr_finish), .mr_prime(mr_prime),
      .mr_candidate(mr_candidate), .mr_accuracy(mr_accuracy), .mr_reset(mr_reset),
      .busy(busy), .done(done), .prime_valid(prime_valid), .fail(fail),
      .prime_out(prime_out), .tries(tries)
   );

   typedef struct {
      bit          pv;
      bit          fl;
      logic [31:0] pout;
      logic [15:0] tries;
      int          launches;
      logic [31:0] first_cand;
   } exp_t;

   exp_t exp_q[$];
   bit   verdict_q[$];
   int   mode = 0;          // 0: answer after 5 cycles, 1: stale finish only, 2: never answer
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // miller_rabin stand-in
   int t_cnt;
   always @(posedge clk or negedge reset) begin
      int nc;
      if (!reset) begin
         t_cnt     <= 0;
         mr_finish <= 1'b0;
         mr_prime  <= 1'b0;
      end else begin
         mr_finish <= 1'b0;
         if (mr_reset)        nc = 1;
         else if (t_cnt != 0) nc = t_cnt + 1;
         else                 nc = 0;
         t_cnt <= nc;
         if (mode == 0 && nc == 5) begin
            mr_finish <= 1'b1;
            mr_prime  <= (verdict_q.size() != 0) ? verdict_q.pop_front() : 1'b0;
         end else if (mode == 1 && (nc == 1 || nc == 2)) begin
            mr_finish <= 1'b1;
            mr_prime  <= 1'b1;
         end
      end
   end

   // monitor
   int          launch_cnt = 0;
   logic [31:0] first_cand = '0;
   bit          busy_prev = 0, done_prev = 0;
   exp_t        e;
   always @(negedge clk) begin
      if (!reset) begin
         launch_cnt = 0;
         busy_prev  = 0;
         done_prev  = 0;
      end else begin
         if (busy && !busy_prev) launch_cnt = 0;
         if (mr_reset) begin
            if (launch_cnt == 0) first_cand = mr_candidate;
            launch_cnt++;
         end
         if (done_prev) check("done_pulse_width", done, 0);
         if (done) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
               e = exp_q.pop_front();
               check("busy_at_done", busy, 0);
               check("prime_valid", prime_valid, e.pv);
               check("fail", fail, e.fl);
               check("prime_out", prime_out, e.pout);
               check("tries", tries, e.tries);
               check("launches", launch_cnt, e.launches);
               if (e.launches > 0) check("first_candidate", first_cand, e.first_cand);
            end
         end
         busy_prev = busy;
         done_prev = done;
      end
   end

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL search_timeout: got no done within 3000 cycles expected done");
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_search(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] r, input exp_t ex);
      exp_q.push_back(ex);
      @(negedge clk); start = 1'b1; rng_word = w0;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rng_word = w1;
      @(negedge clk); rng_word = r;
      wait_empty();
   endtask

   exp_t x;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_prime_valid", prime_valid, 0);
      check("rst_fail", fail, 0);
      check("rst_prime_out", prime_out, 0);
      check("rst_tries", tries, 0);
      check("rst_mr_candidate", mr_candidate, 0);
      check("rst_mr_reset", mr_reset, 0);
      check("rst_mr_accuracy", mr_accuracy, 64'd20);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // prime on first try
      mode = 0; verdict_q = '{1};
      x = '{pv:1, fl:0, pout:32'h8000000B, tries:16'd1, launches:1, first_cand:32'h8000000B};
      run_search(16'h000B, 16'h0000, 16'h1234, x);

      // composite, composite, prime
      verdict_q = '{0, 0, 1};
      x = '{pv:1, fl:0, pout:32'h80090009, tries:16'd3, launches:3, first_cand:32'h80000003};
      run_search(16'h0003, 16'h0000, 16'h0009, x);

      // always composite until MAX_TRIES
      verdict_q = '{0, 0, 0, 0};
      x = '{pv:0, fl:1, pout:32'h0, tries:16'd4, launches:4, first_cand:32'h80000003};
      run_search(16'h0003, 16'h0000, 16'h0009, x);

      // stale finish in guard cycles, then timeout every try
      mode = 1; verdict_q.delete();
      x = '{pv:0, fl:1, pout:32'h0, tries:16'd4, launches:4, first_cand:32'h80000003};
      run_search(16'h0003, 16'h0000, 16'h0009, x);

      // 0x80000001 is divisible by 3
      mode = 0; verdict_q = '{1};
`ifdef PRIME_SIEVE_EN
      x = '{pv:0, fl:1, pout:32'h0, tries:16'd4, launches:0, first_cand:32'h0};
`else
      x = '{pv:1, fl:0, pout:32'h80000001, tries:16'd1, launches:1, first_cand:32'h80000001};
`endif
      run_search(16'h0000, 16'h0000, 16'h0000, x);

      // start while busy, then reset mid-WAIT
      mode = 2; verdict_q.delete();
      @(negedge clk); start = 1'b1; rng_word = 16'h000B;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rng_word = 16'h0000;
      begin
         int n = 0;
         while (launch_cnt != 1 && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      check("abuse_first_launch", launch_cnt, 1);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      check("abuse_no_restart_launches", launch_cnt, 1);
      check("abuse_still_busy", busy, 1);
      check("abuse_tries", tries, 1);
      reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_tries", tries, 0);
      check("abort_done", done, 0);
      check("abort_mr_reset", mr_reset, 0);
      check("abort_mr_candidate", mr_candidate, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // restart after abort
      mode = 0; verdict_q = '{1};
      x = '{pv:1, fl:0, pout:32'h8000000B, tries:16'd1, launches:1, first_cand:32'h8000000B};
      run_search(16'h000B, 16'h0000, 16'h1234, x);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
